wbnarrow: RTL and testbench
===========================

WBNARROW -- requirements
Module: wbnarrow

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: _reset_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have slave-side ports: s_cyc_i in 1, s_stb_i in 1, s_we_i in 1, s_sel_i in 4 (byte lanes), s_adr_i in 18 [19:2], s_dat_i in 32, s_dat_o out 32, s_ack_o out 1, s_stall_o out 1, s_err_o out 1; Wishbone B4 pipelined responder.
REQ-004 SHALL have master-side ports: m_cyc_o out 1, m_stb_o out 1, m_we_o out 1, m_sel_o out 2, m_adr_o out 19 [19:1], m_dat_o out 16, m_dat_i in 16, m_ack_i in 1, m_stall_i in 1; Wishbone B4 pipelined initiator driving a 16-bit responder (e.g. the SRAM controller).

Function
REQ-005 SHALL split each accepted 32-bit transfer into at most two 16-bit master transfers: low half first (m_adr_o = {s_adr_i,0}, m_sel_o = sel[1:0], m_dat_o = dat[15:0]), then high half (m_adr_o = {s_adr_i,1}, m_sel_o = sel[3:2], m_dat_o = dat[31:16]).
REQ-006 SHALL accept a slave request when s_cyc_i & s_stb_i & ~s_stall_o on a rising edge, latching adr, sel, we, dat.
REQ-007 SHALL drive s_stall_o = 1 in every state except IDLE.
REQ-008 FSM states SHALL be IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE.
REQ-009 Transitions: IDLE->LO_REQ on accept if sel[1:0]!=0, else ->HI_REQ if sel[3:2]!=0, else ->DONE; *_REQ->*_WAIT when m_stb_o & ~m_stall_i; LO_WAIT->HI_REQ on m_ack_i if sel[3:2]!=0, else ->DONE; HI_WAIT->DONE on m_ack_i; DONE->IDLE unconditionally.
REQ-010 m_stb_o SHALL be 1 only in LO_REQ/HI_REQ and held while m_stall_i=1; at most one master transfer outstanding.
REQ-011 m_cyc_o SHALL be 1 in LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, including between halves; 0 in IDLE and DONE.
REQ-012 m_we_o SHALL equal latched we throughout the master cycle.
REQ-013 On reads, m_dat_i SHALL be captured on m_ack_i into s_dat_o[15:0] (low) or s_dat_o[31:16] (high); skipped halves SHALL read as 0.
REQ-014 s_ack_o SHALL be a one-cycle pulse in DONE; s_dat_o valid in that cycle.
REQ-015 With a zero-stall responder acking one cycle after stb, full-width transfer latency SHALL be 5 cycles from accept edge to s_ack_o; sel=0000 latency SHALL be 1 cycle with no master activity.
REQ-016 If s_cyc_i falls in *_REQ: drop m_stb_o/m_cyc_o next cycle, go IDLE, no s_ack_o. If it falls in *_WAIT: wait for m_ack_i, then IDLE, no s_ack_o, no further half.
REQ-017 m_ack_i outside *_WAIT SHALL be ignored.

Reset
REQ-018 On _reset_i=0, immediately: state IDLE; m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o = 0; m_sel_o=0; m_adr_o=0; m_dat_o=0; s_dat_o=0; s_stall_o=0 (IDLE).
REQ-019 Reset mid-transfer SHALL abandon it with no s_ack_o after release.

Configuration
REQ-020 Macro WBNARROW_TIMEOUT_EN SHALL enable an 8-bit watchdog cleared on each *_WAIT entry, counting in *_WAIT; at 255 cycles without m_ack_i: s_err_o one-cycle pulse (no s_ack_o), m_cyc_o drops, state IDLE.
REQ-021 Without WBNARROW_TIMEOUT_EN, s_err_o SHALL be tied 0 and *_WAIT SHALL wait indefinitely.

Structure
REQ-022 State encodings and timeout limit (255) SHALL live in shared include wbnarrow_defs.vh.
REQ-023 Watchdog SHALL be sub-module wbnarrow_wdog, instantiated only under WBNARROW_TIMEOUT_EN.

Verification
REQ-024 Read, sel=1111, adr=0x00010, responder returns 0x1234 then 0xABCD -> m_adr_o 0x00020 then 0x00021; s_dat_o=0xABCD1234; s_ack_o 5 cycles after accept.
REQ-025 Write sel=1100, dat=0xDEADBEEF -> single master write adr odd, m_sel_o=11, m_dat_o=0xDEAD; one s_ack_o.
REQ-026 sel=0000 -> no m_cyc_o; s_ack_o 1 cycle after accept.
REQ-027 m_stall_i held 3 cycles on low half -> m_stb_o held 4 cycles, address/data stable; result correct.
REQ-028 s_cyc_i dropped during LO_WAIT -> high half never issued, no s_ack_o; _reset_i pulsed mid-transfer -> all outputs 0 immediately.
REQ-029 With WBNARROW_TIMEOUT_EN, responder never acks -> s_err_o pulse after 255 WAIT cycles, m_cyc_o=0, next request served normally.

Source files
------------

// File: rtl/wbnarrow_pkg.sv
// Types and constants shared by the wbnarrow bridge, its watchdog and its bench.
`include "wbnarrow_defs.vh"

package wbnarrow_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = `WBNARROW_ST_IDLE,
      ST_LO_REQ  = `WBNARROW_ST_LO_REQ,
      ST_LO_WAIT = `WBNARROW_ST_LO_WAIT,
      ST_HI_REQ  = `WBNARROW_ST_HI_REQ,
      ST_HI_WAIT = `WBNARROW_ST_HI_WAIT,
      ST_DONE    = `WBNARROW_ST_DONE
   } state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = `WBNARROW_TIMEOUT_LIMIT;

   function automatic logic [15:0] half_of(input logic [31:0] word, input logic hi);
      return hi ? word[31:16] : word[15:0];
   endfunction

endpackage

// File: rtl/wbnarrow_if.sv
// Bundles the 32-bit responder bus (s_*) and the 16-bit initiator bus (m_*) of the bridge.
// Handshake: a beat transfers on a rising edge where cyc & stb & ~stall; ack answers one beat.
interface wbnarrow_if;
   logic        s_cyc_i;
   logic        s_stb_i;
   logic        s_we_i;
   logic [3:0]  s_sel_i;
   logic [19:2] s_adr_i;
   logic [31:0] s_dat_i;
   logic [31:0] s_dat_o;
   logic        s_ack_o;
   logic        s_stall_o;
   logic        s_err_o;

   logic        m_cyc_o;
   logic        m_stb_o;
   logic        m_we_o;
   logic [1:0]  m_sel_o;
   logic [19:1] m_adr_o;
   logic [15:0] m_dat_o;
   logic [15:0] m_dat_i;
   logic        m_ack_i;
   logic        m_stall_i;

   modport slave (
      input  s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i,
      output s_dat_o, s_ack_o, s_stall_o, s_err_o
   );

   modport master (
      output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
      input  m_dat_i, m_ack_i, m_stall_i
   );
endinterface

// File: rtl/wbnarrow_defs.vh
// Shared state encodings and watchdog limit for the wbnarrow 32->16 bridge.
`ifndef WBNARROW_DEFS_VH
`define WBNARROW_DEFS_VH

`define WBNARROW_ST_IDLE       3'd0
`define WBNARROW_ST_LO_REQ     3'd1
`define WBNARROW_ST_LO_WAIT    3'd2
`define WBNARROW_ST_HI_REQ     3'd3
`define WBNARROW_ST_HI_WAIT    3'd4
`define WBNARROW_ST_DONE       3'd5

`define WBNARROW_TIMEOUT_LIMIT 8'd255

`endif

// File: rtl/wbnarrow_wdog.sv
// Wait-state watchdog for wbnarrow; only built when WBNARROW_TIMEOUT_EN is defined.
`ifdef WBNARROW_TIMEOUT_EN
module wbnarrow_wdog
   import wbnarrow_pkg::*;
(
   input  logic clk_i,
   input  logic _reset_i,
   input  logic run,
   output logic expired
);
   logic [7:0] cnt;

   // Counter restarts whenever the bridge leaves a wait state, so each half gets a fresh budget.
   always_ff @(posedge clk_i or negedge _reset_i) begin
      if (!_reset_i) begin
         cnt <= 8'd0;
      end else if (!run) begin
         cnt <= 8'd0;
      end else if (!expired) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expired = run & (cnt == TIMEOUT_LIMIT - 8'd1);
endmodule
`endif

// File: rtl/wbnarrow.sv
// Wishbone B4 pipelined 32-bit responder to 16-bit initiator bridge (low half, then high half).
// Optional wait-state watchdog with s_err_o reporting: define WBNARROW_TIMEOUT_EN.
module wbnarrow
   import wbnarrow_pkg::*;
(
   input  logic       clk_i,
   input  logic       _reset_i,
   wbnarrow_if.slave  s,
   wbnarrow_if.master m,
   output state_t     dbg_state
);
   state_t      state, state_nx;
   logic [19:2] adr_q;
   logic [3:0]  sel_q;
   logic        we_q;
   logic [31:0] dat_q;
   logic [31:0] rdat_q;
   logic        abort_q;

   logic accept, in_wait, abort_now, timeout;
   logic bus_cyc, bus_stb, stall, ack, hi_half;

   assign accept    = (state == ST_IDLE) & s.s_cyc_i & s.s_stb_i;
   assign in_wait   = (state == ST_LO_WAIT) | (state == ST_HI_WAIT);
   assign abort_now = abort_q | ~s.s_cyc_i;

`ifdef WBNARROW_TIMEOUT_EN
   logic err_q;

   wbnarrow_wdog u_wdog (
      .clk_i    (clk_i),
      ._reset_i (_reset_i),
      .run      (in_wait),
      .expired  (timeout)
   );

   // A late ack on the expiry edge still wins, so the error only fires when none arrived.
   always_ff @(posedge clk_i or negedge _reset_i) begin
      if (!_reset_i) err_q <= 1'b0;
      else           err_q <= in_wait & ~m.m_ack_i & timeout;
   end

   assign s.s_err_o = err_q;
`else
   assign timeout   = 1'b0;
   assign s.s_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge _reset_i) begin
      if (!_reset_i) state <= ST_IDLE;
      else           state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      bus_cyc  = 1'b0;
      bus_stb  = 1'b0;
      stall    = 1'b1;
      ack      = 1'b0;
      hi_half  = 1'b0;
      case (state)
         ST_IDLE: begin
            stall = 1'b0;
            if (accept) begin
               if (|s.s_sel_i[1:0])      state_nx = ST_LO_REQ;
               else if (|s.s_sel_i[3:2]) state_nx = ST_HI_REQ;
               else                      state_nx = ST_DONE;
            end
         end
         ST_LO_REQ: begin
            bus_cyc = 1'b1;
            bus_stb = 1'b1;
            if (!s.s_cyc_i)        state_nx = ST_IDLE;
            else if (!m.m_stall_i) state_nx = ST_LO_WAIT;
         end
         ST_LO_WAIT: begin
            bus_cyc = 1'b1;
            if (m.m_ack_i) begin
               if (abort_now)         state_nx = ST_IDLE;
               else if (|sel_q[3:2])  state_nx = ST_HI_REQ;
               else                   state_nx = ST_DONE;
            end else if (timeout) begin
               state_nx = ST_IDLE;
            end
         end
         ST_HI_REQ: begin
            bus_cyc = 1'b1;
            bus_stb = 1'b1;
            hi_half = 1'b1;
            if (!s.s_cyc_i)        state_nx = ST_IDLE;
            else if (!m.m_stall_i) state_nx = ST_HI_WAIT;
         end
         ST_HI_WAIT: begin
            bus_cyc = 1'b1;
            hi_half = 1'b1;
            if (m.m_ack_i)    state_nx = abort_now ? ST_IDLE : ST_DONE;
            else if (timeout) state_nx = ST_IDLE;
         end
         ST_DONE: begin
            ack      = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Read data is cleared on accept so a skipped half returns zero.
   always_ff @(posedge clk_i or negedge _reset_i) begin
      if (!_reset_i) begin
         adr_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         dat_q   <= '0;
         rdat_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         if (accept) begin
            adr_q   <= s.s_adr_i;
            sel_q   <= s.s_sel_i;
            we_q    <= s.s_we_i;
            dat_q   <= s.s_dat_i;
            rdat_q  <= '0;
            abort_q <= 1'b0;
         end
         if (in_wait & ~s.s_cyc_i) abort_q <= 1'b1;
         if (m.m_ack_i & ~we_q) begin
            if (state == ST_LO_WAIT) rdat_q[15:0]  <= m.m_dat_i;
            if (state == ST_HI_WAIT) rdat_q[31:16] <= m.m_dat_i;
         end
      end
   end

   assign m.m_cyc_o   = bus_cyc;
   assign m.m_stb_o   = bus_stb;
   assign m.m_we_o    = we_q;
   assign m.m_adr_o   = {adr_q, hi_half};
   assign m.m_sel_o   = hi_half ? sel_q[3:2] : sel_q[1:0];
   assign m.m_dat_o   = half_of(dat_q, hi_half);
   assign s.s_dat_o   = rdat_q;
   assign s.s_ack_o   = ack;
   assign s.s_stall_o = stall;
   assign dbg_state   = state;
endmodule

// File: tb/tb_wbnarrow.sv
// Bench for wbnarrow: directed and random 32-bit transfers against a byte-level memory model.
`define CHK(tag, o, e) chk(tag, 80'(o), 80'(e))

module tb_wbnarrow;
  import wbnarrow_pkg::*;

  localparam int XW = 38;   // {we, adr[19:1], sel[1:0], write data}

  logic   clk_i = 1'b0;
  logic   _reset_i;
  state_t dbg_state;

  wbnarrow_if bus ();

  wbnarrow dut (
    .clk_i     (clk_i),
    ._reset_i  (_reset_i),
    .s         (bus),
    .m         (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [XW-1:0] exp_q[$];
  logic [XW-1:0] obs_q[$];
  logic [8:0]    run_q[$];
  logic [7:0]    ref_bytes [1024];

  // responder-owned state
  logic [15:0] mem16 [512];
  bit          pending;
  logic [15:0] pend_dat;
  int          stall_done;
  int          stb_run;
  bit          stable;
  logic [19:1] first_adr;
  logic [15:0] first_dat;
  logic [1:0]  first_sel;
  int          cyc_cycles;

  // main-owned controls
  int stall_req;
  bit rand_stall, no_ack, force_ack;

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 40503 + 12345) ^ (i << 7));
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] out_vec();
    return {5'b0, bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, bus.m_sel_o, bus.m_adr_o, bus.m_dat_o,
            bus.s_dat_o, bus.s_ack_o, bus.s_stall_o, bus.s_err_o};
  endfunction

  // 16-bit responder: optional stalls, ack one cycle after the accepted strobe.
  initial begin
    for (int i = 0; i < 512; i++) mem16[i] = init_word(i);
    bus.m_ack_i = 1'b0; bus.m_stall_i = 1'b0; bus.m_dat_i = '0;
    pending = 0; pend_dat = '0; stall_done = 0; stb_run = 0; stable = 1;
    first_adr = '0; first_dat = '0; first_sel = '0; cyc_cycles = 0;
    forever begin
      @(negedge clk_i);
      if (!_reset_i) begin
        pending = 0; stb_run = 0; bus.m_ack_i = 1'b0; bus.m_stall_i = 1'b0;
      end else begin
        bus.m_ack_i = (pending && !no_ack) || force_ack;
        bus.m_dat_i = pend_dat;
        pending = 0;
        if (bus.m_cyc_o) cyc_cycles++;
        if (bus.m_stb_o) begin
          if (stb_run == 0) begin
            first_adr = bus.m_adr_o; first_dat = bus.m_dat_o; first_sel = bus.m_sel_o; stable = 1;
          end else if (bus.m_adr_o !== first_adr || bus.m_dat_o !== first_dat || bus.m_sel_o !== first_sel) begin
            stable = 0;
          end
          stb_run++;
          if (stall_done < stall_req) begin
            bus.m_stall_i = 1'b1; stall_done++;
          end else begin
            bus.m_stall_i = (rand_stall && $urandom_range(0, 3) == 0);
          end
          if (!bus.m_stall_i) begin
            obs_q.push_back({bus.m_we_o, bus.m_adr_o, bus.m_sel_o, bus.m_we_o ? bus.m_dat_o : 16'h0});
            run_q.push_back({stb_run[7:0], stable});
            stb_run = 0;
            if (bus.m_we_o) begin
              if (bus.m_sel_o[0]) mem16[bus.m_adr_o[9:1]][7:0]  = bus.m_dat_o[7:0];
              if (bus.m_sel_o[1]) mem16[bus.m_adr_o[9:1]][15:8] = bus.m_dat_o[15:8];
            end else begin
              pend_dat = mem16[bus.m_adr_o[9:1]];
            end
            pending = 1;
          end
        end else begin
          bus.m_stall_i = 1'b0;
        end
      end
    end
  end

  // Reference: a 32-bit access touches only halves with any byte lane enabled, low half first.
  task automatic model(input logic we, input logic [3:0] sel, input logic [19:2] adr,
                       input logic [31:0] dat, output logic [31:0] rd, output int nh);
    rd = '0; nh = 0; exp_q.delete();
    for (int h = 0; h < 2; h++) begin
      logic [1:0] hs;
      hs = sel[2*h +: 2];
      if (hs != 2'b00) begin
        nh++;
        exp_q.push_back({we, adr, 1'(h), hs, we ? dat[16*h +: 16] : 16'h0});
        for (int b = 0; b < 2; b++) begin
          int idx;
          idx = {22'd0, adr[9:2], 2'(2*h + b)};
          if (we && hs[b]) ref_bytes[idx] = dat[8*(2*h+b) +: 8];
          if (!we)         rd[8*(2*h+b) +: 8] = ref_bytes[idx];
        end
      end
    end
  endtask

  task automatic drive_req(input logic we, input logic [3:0] sel, input logic [19:2] adr, input logic [31:0] dat);
    @(negedge clk_i);
    bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1; bus.s_we_i = we;
    bus.s_sel_i = sel; bus.s_adr_i = adr; bus.s_dat_i = dat;
    @(negedge clk_i);
    bus.s_stb_i = 1'b0;
  endtask

  // extra < 0 skips the latency check; otherwise it is the number of inserted stall cycles.
  task automatic run_xfer(input logic we, input logic [3:0] sel, input logic [19:2] adr,
                          input logic [31:0] dat, input int extra);
    logic [31:0] exp_rd;
    int nh, lat, ob, n_new;
    model(we, sel, adr, dat, exp_rd, nh);
    ob = obs_q.size();
    drive_req(we, sel, adr, dat);
    lat = 1;
    while (!bus.s_ack_o && !bus.s_err_o && lat < 400) begin
      @(negedge clk_i);
      lat++;
    end
    `CHK("s_ack", bus.s_ack_o, 1'b1);
    if (extra >= 0) `CHK("latency", lat, 1 + 2*nh + extra);
    if (!we) `CHK("rdata", bus.s_dat_o, exp_rd);
    @(negedge clk_i);
    bus.s_cyc_i = 1'b0;
    `CHK("ack_pulse", bus.s_ack_o, 1'b0);
    n_new = obs_q.size() - ob;
    `CHK("n_xfers", n_new, nh);
    for (int k = 0; k < nh && k < n_new; k++) begin
      n_checks++;
      if (obs_q[ob+k] !== exp_q[k]) begin
        n_errors++;
        $error("FAIL xfer: observed %0h expected %0h", obs_q[ob+k], exp_q[k]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int rb, cb, acks, lat, ob;
    bit found;
    for (int i = 0; i < 512; i++) begin
      ref_bytes[2*i]   = init_word(i)[7:0];
      ref_bytes[2*i+1] = init_word(i)[15:8];
    end
    bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0; bus.s_we_i = 1'b0;
    bus.s_sel_i = '0; bus.s_adr_i = '0; bus.s_dat_i = '0;
    stall_req = 0; rand_stall = 0; no_ack = 0; force_ack = 0;

    // reset state
    _reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    `CHK("reset_outputs", out_vec(), 80'd0);
    `CHK("reset_state", dbg_state, ST_IDLE);
    _reset_i = 1'b1;
    @(negedge clk_i);

    // full-width write then read back: 0x1234 at 0x00020, 0xABCD at 0x00021
    run_xfer(1'b1, 4'b1111, 18'h00010, 32'hABCD1234, 0);
    run_xfer(1'b0, 4'b1111, 18'h00010, 32'h0, 0);
    `CHK("read_abcd1234", bus.s_dat_o, 32'hABCD1234);

    // high-half-only write
    run_xfer(1'b1, 4'b1100, 18'h00123, 32'hDEADBEEF, 0);
    run_xfer(1'b0, 4'b0011, 18'h00123, 32'h0, 0);

    // sel=0000: one-cycle answer and no master activity
    cb = cyc_cycles;
    run_xfer(1'b0, 4'b0000, 18'h00055, 32'h0, 0);
    `CHK("sel0_no_cyc", cyc_cycles - cb, 0);
    `CHK("sel0_rdata", bus.s_dat_o, 32'h0);

    // three stall cycles on the low half
    rb = run_q.size();
    stall_req += 3;
    run_xfer(1'b0, 4'b1111, 18'h00042, 32'h0, 3);
    `CHK("stall_stb_hold", run_q[rb][8:1], 4);
    `CHK("stall_stable", run_q[rb][0], 1'b1);

    // stray ack while idle is ignored
    @(negedge clk_i);
    force_ack = 1;
    repeat (2) @(negedge clk_i);
    force_ack = 0;
    @(negedge clk_i);
    `CHK("stray_ack_idle", {bus.s_ack_o, bus.s_stall_o, bus.m_cyc_o}, 3'b000);

    // s_cyc_i dropped in the low-half wait: no high half, no ack
    ob = obs_q.size();
    drive_req(1'b0, 4'b1111, 18'h00077, 32'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dbg_state == ST_LO_WAIT) found = 1;
      else @(negedge clk_i);
    end
    `CHK("abort_reach_wait", found, 1'b1);
    bus.s_cyc_i = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (bus.s_ack_o) acks++;
    end
    `CHK("abort_no_ack", acks, 0);
    `CHK("abort_one_half", obs_q.size() - ob, 1);
    `CHK("abort_idle", {bus.m_cyc_o, bus.s_stall_o}, 2'b00);

    // reset asserted while a request is on the master bus
    drive_req(1'b0, 4'b1111, 18'h3FFFF, 32'h5555AAAA);
    `CHK("pre_reset_stb", bus.m_stb_o, 1'b1);
    _reset_i = 1'b0;
    #1;
    `CHK("reset_mid_outputs", out_vec(), 80'd0);
    bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
    repeat (2) @(negedge clk_i);
    _reset_i = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (bus.s_ack_o) acks++;
    end
    `CHK("reset_no_ack", acks, 0);

`ifdef WBNARROW_TIMEOUT_EN
    // responder never acks: error after 255 wait cycles
    no_ack = 1;
    drive_req(1'b0, 4'b1111, 18'h00099, 32'h0);
    lat = 1;
    while (!bus.s_err_o && !bus.s_ack_o && lat < 400) begin
      @(negedge clk_i);
      lat++;
    end
    `CHK("tmo_err", bus.s_err_o, 1'b1);
    `CHK("tmo_latency", lat, 257);
    `CHK("tmo_no_ack", bus.s_ack_o, 1'b0);
    `CHK("tmo_cyc_drop", bus.m_cyc_o, 1'b0);
    @(negedge clk_i);
    bus.s_cyc_i = 1'b0;
    no_ack = 0;
    `CHK("tmo_err_pulse", bus.s_err_o, 1'b0);
    run_xfer(1'b0, 4'b1111, 18'h00099, 32'h0, 0);
`endif

    // random transfers, zero-stall then with random stalls
    for (int i = 0; i < 30; i++) begin
      rand_stall = (i >= 8);
      run_xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 18'($urandom),
               $urandom, rand_stall ? -1 : 0);
    end

    if (n_errors == 0) $display("PASS: %0d checks", n_checks);
    else               $display("FAIL: %0d of %0d checks failed", n_errors, n_checks);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
